// File: rtl/fifo_sync_param_if.sv
// Handshake and status bundle for the parametrised synchronous FIFO.
// The master drives write/read requests; the slave (the FIFO) returns data and status.
interface fifo_sync_param_if #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 512
);
  logic [WIDTH-1:0]       din;
  logic                   wr_en;
  logic                   rd_en;
  logic                   err_clr;
  logic [WIDTH-1:0]       dout;
  logic                   full;
  logic                   empty;
  logic                   almost_full;
  logic                   almost_empty;
  logic [$clog2(DEPTH):0] count;
  logic                   overflow;
  logic                   underflow;

  modport master (
    output din, wr_en, rd_en, err_clr,
    input  dout, full, empty,
    input  almost_full, almost_empty,
    input  count, overflow, underflow
  );

  modport slave (
    input  din, wr_en, rd_en, err_clr,
    output dout, full, empty,
    output almost_full, almost_empty,
    output count, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_param.sv
// Single-clock FIFO with count, almost flags and sticky errors.
// Define FIFO_FWFT_EN for first-word fall-through; default is 1-cycle read latency.
module fifo_sync_param #(
  parameter int WIDTH      = 512,
  parameter int DEPTH      = 512,
  parameter int AFULL_LVL  = 16,
  parameter int AEMPTY_LVL = 4
) (
  input logic              clk,
  input logic              rst_n,
  fifo_sync_param_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef logic [CW-1:0] cnt_t;
  typedef logic [AW-1:0] ptr_t;

  localparam cnt_t C_DEPTH  = cnt_t'(DEPTH);
  localparam cnt_t C_AFULL  = cnt_t'(AFULL_LVL);
  localparam cnt_t C_AEMPTY = cnt_t'(AEMPTY_LVL);
  localparam cnt_t C_ONE    = cnt_t'(1);
  localparam ptr_t P_ONE    = ptr_t'(1);

  // Reset asserts immediately, releases two clocks later.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  logic [WIDTH-1:0] r_mem [DEPTH];
  ptr_t             r_wptr;
  ptr_t             r_rptr;
  cnt_t             r_count;
  logic [WIDTH-1:0] r_dout;
  logic             r_ovf;
  logic             r_udf;

  logic w_full;
  logic w_empty;
  logic w_wr_ok;
  logic w_rd_ok;
  logic w_mem_we;
  logic w_mem_re;

  assign w_full  = (r_count == C_DEPTH);
  assign w_wr_ok = bus.wr_en & ~w_full;
  assign w_rd_ok = bus.rd_en & ~w_empty;

`ifdef FIFO_FWFT_EN
  // Head word lives in r_dout; the array holds the rest.
  logic r_dval;
  cnt_t w_mcnt;
  logic w_mem_nz;
  logic w_load;
  logic w_bypass;

  assign w_empty  = ~r_dval;
  assign w_mcnt   = r_count - cnt_t'(r_dval);
  assign w_mem_nz = (w_mcnt != '0);
  assign w_load   = ~r_dval | w_rd_ok;
  assign w_bypass = w_load & ~w_mem_nz & w_wr_ok;
  assign w_mem_we = w_wr_ok & ~w_bypass & w_rst_n;
  assign w_mem_re = w_load & w_mem_nz;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_dval <= 1'b0;
      r_dout <= '0;
    end else if (w_load) begin
      r_dval <= w_mem_nz | w_wr_ok;
      unique case (1'b1)
        w_mem_re: r_dout <= r_mem[r_rptr];
        w_bypass: r_dout <= bus.din;
        default:  ;
      endcase
    end
  end
`else
  assign w_empty  = (r_count == '0);
  assign w_mem_we = w_wr_ok & w_rst_n;
  assign w_mem_re = w_rd_ok;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n)      r_dout <= '0;
    else if (w_mem_re) r_dout <= r_mem[r_rptr];
  end
`endif

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[r_wptr] <= bus.din;
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_mem_we) r_wptr <= r_wptr + P_ONE;
      if (w_mem_re) r_rptr <= r_rptr + P_ONE;
    end
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_count <= '0;
    end else begin
      unique case (1'b1)
        (w_wr_ok & ~w_rd_ok): r_count <= r_count + C_ONE;
        (w_rd_ok & ~w_wr_ok): r_count <= r_count - C_ONE;
        default:              ;
      endcase
    end
  end

  // Set beats clear when both happen together.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      r_ovf <= (bus.wr_en & ~w_wr_ok) | (r_ovf & ~bus.err_clr);
      r_udf <= (bus.rd_en & ~w_rd_ok) | (r_udf & ~bus.err_clr);
    end
  end

  assign bus.dout         = r_dout;
  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = (r_count >= C_AFULL);
  assign bus.almost_empty = (r_count <= C_AEMPTY);
  assign bus.count        = r_count;
  assign bus.overflow     = r_ovf;
  assign bus.underflow    = r_udf;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param at DEPTH=16, WIDTH=8.
// Covers reset, fill/drain flags, errors, streaming and corner handshakes.
module tb_fifo_sync_param;

  localparam int W  = 8;
  localparam int D  = 16;
  localparam int AF = 12;
  localparam int AE = 4;
`ifdef FIFO_FWFT_EN
  localparam int RD_OFS = 1;
`else
  localparam int RD_OFS = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_run = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  fifo_sync_param_if #(.WIDTH(W), .DEPTH(D)) bus ();

  fifo_sync_param #(
    .WIDTH(W), .DEPTH(D),
    .AFULL_LVL(AF), .AEMPTY_LVL(AE)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.err_clr = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    bus.din = '0;
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    n_run++;
    if (bus.empty !== 1'b1 || bus.almost_empty !== 1'b1 ||
        bus.full !== 1'b0 || bus.almost_full !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got e=%b ae=%b f=%b af=%b want 1 1 0 0",
               bus.empty, bus.almost_empty, bus.full, bus.almost_full);
    end
    n_run++;
    if (bus.count !== 5'd0 || bus.dout !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_count_dout: got %0d/%h want 0/00",
               bus.count, bus.dout);
    end
    n_run++;
    if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_err: got ovf=%b udf=%b want 0 0",
               bus.overflow, bus.underflow);
    end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= D; i++) begin
      bus.din = 8'(i);
      bus.wr_en = 1'b1;
      tick();
      n_run++;
      if (bus.count !== 5'(i) || bus.empty !== 1'b0) begin
        n_fail++;
        $display("FAIL fill_count[%0d]: got %0d e=%b want %0d e=0",
                 i, bus.count, bus.empty, i);
      end
      n_run++;
      if (bus.almost_full !== (i >= AF) || bus.full !== (i == D) ||
          bus.almost_empty !== (i <= AE)) begin
        n_fail++;
        $display("FAIL fill_flags[%0d]: got af=%b f=%b ae=%b want %b %b %b",
                 i, bus.almost_full, bus.full, bus.almost_empty,
                 i >= AF, i == D, i <= AE);
      end
    end
    bus.din = 8'h11;
    tick();
    bus.wr_en = 1'b0;
    n_run++;
    if (bus.count !== 5'd16 || bus.overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow: got cnt=%0d ovf=%b want 16 1",
               bus.count, bus.overflow);
    end
  endtask

  task automatic test_drain();
    if (RD_OFS == 1) begin
      n_run++;
      if (bus.dout !== 8'h01) begin
        n_fail++;
        $display("FAIL fwft_head: got %h want 01", bus.dout);
      end
    end
    for (int i = 1; i <= D; i++) begin
      bus.rd_en = 1'b1;
      tick();
      n_run++;
      if (bus.count !== 5'(D - i)) begin
        n_fail++;
        $display("FAIL drain_count[%0d]: got %0d want %0d",
                 i, bus.count, D - i);
      end
      if (i + RD_OFS <= D) begin
        n_run++;
        if (bus.dout !== 8'(i + RD_OFS)) begin
          n_fail++;
          $display("FAIL drain_data[%0d]: got %h want %h",
                   i, bus.dout, 8'(i + RD_OFS));
        end
      end
    end
    tick();
    n_run++;
    if (bus.underflow !== 1'b1 || bus.count !== 5'd0 ||
        bus.empty !== 1'b1) begin
      n_fail++;
      $display("FAIL underflow: got udf=%b cnt=%0d e=%b want 1 0 1",
               bus.underflow, bus.count, bus.empty);
    end
`ifndef FIFO_FWFT_EN
    n_run++;
    if (bus.dout !== 8'h10) begin
      n_fail++;
      $display("FAIL dout_hold: got %h want 10", bus.dout);
    end
`endif
    bus.rd_en = 1'b0;
    bus.err_clr = 1'b1;
    tick();
    n_run++;
    if (bus.underflow !== 1'b0 || bus.overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clr: got udf=%b ovf=%b want 0 0",
               bus.underflow, bus.overflow);
    end
    bus.rd_en = 1'b1;
    tick();
    n_run++;
    if (bus.underflow !== 1'b1) begin
      n_fail++;
      $display("FAIL set_wins: got udf=%b want 1", bus.underflow);
    end
    bus.rd_en = 1'b0;
    tick();
    idle();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin
      bus.din = 8'(8'h20 + i);
      bus.wr_en = 1'b1;
      tick();
    end
    for (int k = 0; k < 100; k++) begin
      bus.din = 8'(8'h25 + k);
      bus.wr_en = 1'b1;
      bus.rd_en = 1'b1;
      tick();
      n_run++;
      if (bus.count !== 5'd5 || bus.dout !== 8'(8'h20 + k + RD_OFS)) begin
        n_fail++;
        $display("FAIL stream[%0d]: got cnt=%0d d=%h want 5 %h",
                 k, bus.count, bus.dout, 8'(8'h20 + k + RD_OFS));
      end
    end
    bus.wr_en = 1'b0;
    repeat (5) tick();
    bus.rd_en = 1'b0;
    n_run++;
    if (bus.count !== 5'd0 || bus.empty !== 1'b1) begin
      n_fail++;
      $display("FAIL stream_drain: got cnt=%0d e=%b want 0 1",
               bus.count, bus.empty);
    end
  endtask

  task automatic test_full_both();
    for (int i = 0; i < D; i++) begin
      bus.din = 8'(8'h40 + i);
      bus.wr_en = 1'b1;
      tick();
    end
    bus.din = 8'hEE;
    bus.rd_en = 1'b1;
    tick();
    idle();
    n_run++;
    if (bus.count !== 5'd15 || bus.overflow !== 1'b1 ||
        bus.full !== 1'b0) begin
      n_fail++;
      $display("FAIL full_both: got cnt=%0d ovf=%b f=%b want 15 1 0",
               bus.count, bus.overflow, bus.full);
    end
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    bus.rd_en = 1'b1;
    repeat (15) tick();
    bus.rd_en = 1'b0;
    n_run++;
    if (bus.count !== 5'd0 || bus.underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL full_both_drain: got cnt=%0d udf=%b want 0 0",
               bus.count, bus.underflow);
    end
`ifndef FIFO_FWFT_EN
    n_run++;
    if (bus.dout !== 8'h4F) begin
      n_fail++;
      $display("FAIL full_both_last: got %h want 4f", bus.dout);
    end
`endif
  endtask

  task automatic test_empty_both();
    bus.din = 8'h77;
    bus.wr_en = 1'b1;
    bus.rd_en = 1'b1;
    tick();
    idle();
    n_run++;
    if (bus.count !== 5'd1 || bus.underflow !== 1'b1 ||
        bus.empty !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_both: got cnt=%0d udf=%b e=%b want 1 1 0",
               bus.count, bus.underflow, bus.empty);
    end
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    n_run++;
    if (bus.count !== 5'd0 || (RD_OFS == 0 && bus.dout !== 8'h77)) begin
      n_fail++;
      $display("FAIL empty_both_rd: got cnt=%0d d=%h want 0 77",
               bus.count, bus.dout);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 7; i++) begin
      bus.din = 8'(8'h60 + i);
      bus.wr_en = 1'b1;
      tick();
    end
    bus.wr_en = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    n_run++;
    if (bus.count !== 5'd0 || bus.empty !== 1'b1 ||
        bus.almost_empty !== 1'b1 || bus.dout !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_mid: got cnt=%0d e=%b ae=%b d=%h want 0 1 1 00",
               bus.count, bus.empty, bus.almost_empty, bus.dout);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    bus.din = 8'h5A;
    bus.wr_en = 1'b1;
    tick();
    bus.wr_en = 1'b0;
    n_run++;
    if (bus.count !== 5'd1) begin
      n_fail++;
      $display("FAIL post_reset_wr: got cnt=%0d want 1", bus.count);
    end
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    n_run++;
    if (bus.count !== 5'd0 || (RD_OFS == 0 && bus.dout !== 8'h5A)) begin
      n_fail++;
      $display("FAIL post_reset_rd: got cnt=%0d d=%h want 0 5a",
               bus.count, bus.dout);
    end
  endtask

`ifdef FIFO_FWFT_EN
  task automatic test_fwft();
    bus.din = 8'hA5;
    bus.wr_en = 1'b1;
    tick();
    bus.wr_en = 1'b0;
    n_run++;
    if (bus.dout !== 8'hA5 || bus.empty !== 1'b0) begin
      n_fail++;
      $display("FAIL fwft_fall: got d=%h e=%b want a5 0",
               bus.dout, bus.empty);
    end
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    n_run++;
    if (bus.empty !== 1'b1 || bus.count !== 5'd0) begin
      n_fail++;
      $display("FAIL fwft_ack: got e=%b cnt=%0d want 1 0",
               bus.empty, bus.count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_full_both();
    test_empty_both();
    test_reset_mid();
`ifdef FIFO_FWFT_EN
    test_fwft();
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
